// File: rtl/decode_if.sv
// Bundle of the signals the decode stage exchanges with its neighbours:
// the D-stage instruction/PC from fetch, the writeback port into the register
// file, the ID/EX bubble control, and the registered E-stage outputs.
interface decode_if #(
    parameter int XLEN = 32
);
    logic [31:0]     instrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic            FlushE;

    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;

    logic            RegWriteE;
    logic            MemWriteE;
    logic            BranchE;
    logic            JumpE;
    logic            JalrE;
    logic            ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;
    logic            IllegalE;

    // Upstream side (fetch, writeback, hazard unit) drives the D/W inputs.
    modport master (
        output instrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
        input  Rs1D, Rs2D,
        input  RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE,
        input  ResultSrcE, ALUControlE, funct3E,
        input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
        input  Rs1E, Rs2E, RdE, IllegalE
    );

    // The decode stage itself.
    modport slave (
        input  instrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
        output Rs1D, Rs2D,
        output RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE,
        output ResultSrcE, ALUControlE, funct3E,
        output RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
        output Rs1E, Rs2E, RdE, IllegalE
    );
endinterface

// File: rtl/decode.sv
// RV32I instruction-decode stage: control/immediate decode, the 32x32
// architectural register file with write-through bypass, and the ID/EX
// pipeline register feeding execute.
module decode #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input logic     clk,
    input logic     reset,
    decode_if.slave bus
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U
    } immSel_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;

    logic            w_regWrite;
    logic            w_memWrite;
    logic            w_branch;
    logic            w_jump;
    logic            w_jalr;
    logic            w_aluSrc;
    logic [1:0]      w_resultSrc;
    logic [2:0]      w_aluCtl;
    logic            w_illegal;
    immSel_t         w_immSel;
    logic [XLEN-1:0] w_immExt;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    logic [XLEN-1:0] r_regs [32];

    logic            r_regWriteE;
    logic            r_memWriteE;
    logic            r_branchE;
    logic            r_jumpE;
    logic            r_jalrE;
    logic            r_aluSrcE;
    logic [1:0]      r_resultSrcE;
    logic [2:0]      r_aluCtlE;
    logic [2:0]      r_funct3E;
    logic [XLEN-1:0] r_rd1E;
    logic [XLEN-1:0] r_rd2E;
    logic [XLEN-1:0] r_immExtE;
    logic [XLEN-1:0] r_pcE;
    logic [XLEN-1:0] r_pcPlus4E;
    logic [4:0]      r_rs1E;
    logic [4:0]      r_rs2E;
    logic [4:0]      r_rdE;
    logic            r_illegalE;

    assign w_opcode = bus.instrD[6:0];
    assign w_funct3 = bus.instrD[14:12];
    assign w_funct7 = bus.instrD[31:25];
    assign w_rs1    = bus.instrD[19:15];
    assign w_rs2    = bus.instrD[24:20];
    assign w_rd     = bus.instrD[11:7];

    assign bus.Rs1D = w_rs1;
    assign bus.Rs2D = w_rs2;

    // Main control decode; an unsupported opcode or funct zeroes every control.
    always_comb begin
        w_regWrite  = 1'b0;
        w_memWrite  = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_jalr      = 1'b0;
        w_aluSrc    = 1'b0;
        w_resultSrc = 2'b00;
        w_aluCtl    = ALU_ADD;
        w_immSel    = IMM_NONE;
        w_illegal   = 1'b0;
        case (w_opcode)
            OP_LOAD: begin
                w_regWrite  = 1'b1;
                w_aluSrc    = 1'b1;
                w_resultSrc = 2'b01;
                w_immSel    = IMM_I;
            end
            OP_STORE: begin
                w_memWrite = 1'b1;
                w_aluSrc   = 1'b1;
                w_immSel   = IMM_S;
            end
            OP_RTYPE: begin
                w_regWrite = 1'b1;
                case (w_funct3)
                    3'b000:  w_aluCtl = w_funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  w_aluCtl = ALU_SLL;
                    3'b010:  w_aluCtl = ALU_SLT;
                    3'b011:  w_illegal = 1'b1;
                    3'b100:  w_aluCtl = ALU_XOR;
                    3'b101: begin
                        if (w_funct7[5]) w_illegal = 1'b1;
                        else             w_aluCtl  = ALU_SRL;
                    end
                    3'b110:  w_aluCtl = ALU_OR;
                    default: w_aluCtl = ALU_AND;
                endcase
            end
            OP_IALU: begin
                w_regWrite = 1'b1;
                w_aluSrc   = 1'b1;
                w_immSel   = IMM_I;
                case (w_funct3)
                    3'b000:  w_aluCtl = ALU_ADD;
                    3'b001: begin
                        if (w_funct7 != 7'd0) w_illegal = 1'b1;
                        else                  w_aluCtl  = ALU_SLL;
                    end
                    3'b010:  w_aluCtl = ALU_SLT;
                    3'b011:  w_illegal = 1'b1;
                    3'b100:  w_aluCtl = ALU_XOR;
                    3'b101: begin
                        if (w_funct7 != 7'd0) w_illegal = 1'b1;
                        else                  w_aluCtl  = ALU_SRL;
                    end
                    3'b110:  w_aluCtl = ALU_OR;
                    default: w_aluCtl = ALU_AND;
                endcase
            end
            OP_BRANCH: begin
                w_branch = 1'b1;
                w_aluCtl = ALU_SUB;
                w_immSel = IMM_B;
            end
            OP_JAL: begin
                w_regWrite  = 1'b1;
                w_jump      = 1'b1;
                w_resultSrc = 2'b10;
                w_immSel    = IMM_J;
            end
            OP_JALR: begin
                w_regWrite  = 1'b1;
                w_jalr      = 1'b1;
                w_aluSrc    = 1'b1;
                w_resultSrc = 2'b10;
                w_immSel    = IMM_I;
            end
            OP_LUI: begin
                w_regWrite = 1'b1;
                w_aluSrc   = 1'b1;
                w_immSel   = IMM_U;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_regWrite  = 1'b0;
            w_memWrite  = 1'b0;
            w_branch    = 1'b0;
            w_jump      = 1'b0;
            w_jalr      = 1'b0;
            w_aluSrc    = 1'b0;
            w_resultSrc = 2'b00;
            w_aluCtl    = ALU_ADD;
        end
    end

    // Immediate assembly, sign-extended from instruction bit 31.
    always_comb begin
        w_immExt = '0;
        case (w_immSel)
            IMM_I:   w_immExt = {{20{bus.instrD[31]}}, bus.instrD[31:20]};
            IMM_S:   w_immExt = {{20{bus.instrD[31]}}, bus.instrD[31:25], bus.instrD[11:7]};
            IMM_B:   w_immExt = {{20{bus.instrD[31]}}, bus.instrD[7], bus.instrD[30:25],
                                 bus.instrD[11:8], 1'b0};
            IMM_J:   w_immExt = {{12{bus.instrD[31]}}, bus.instrD[19:12], bus.instrD[20],
                                 bus.instrD[30:21], 1'b0};
            IMM_U:   w_immExt = {bus.instrD[31:12], 12'b0};
            default: w_immExt = '0;
        endcase
    end

    // Register reads: x0 is hard zero, a same-cycle writeback is bypassed, and
    // lui sees a zero rs1 so the execute-stage add passes the immediate through.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_opcode != OP_LUI && w_rs1 != 5'd0) begin
            if (bus.RegWriteW && bus.RdW == w_rs1) w_rd1 = bus.ResultW;
            else                                   w_rd1 = r_regs[w_rs1];
        end
        if (w_rs2 != 5'd0) begin
            if (bus.RegWriteW && bus.RdW == w_rs2) w_rd2 = bus.ResultW;
            else                                   w_rd2 = r_regs[w_rs2];
        end
    end

    // Register file write port; writes to x0 are dropped so entry 0 stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (bus.RegWriteW && bus.RdW != 5'd0) begin
            r_regs[bus.RdW] <= bus.ResultW;
        end
    end

    // ID/EX pipeline register; a flush loads an all-zero NOP bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || bus.FlushE) begin
            r_regWriteE  <= 1'b0;
            r_memWriteE  <= 1'b0;
            r_branchE    <= 1'b0;
            r_jumpE      <= 1'b0;
            r_jalrE      <= 1'b0;
            r_aluSrcE    <= 1'b0;
            r_resultSrcE <= 2'b00;
            r_aluCtlE    <= 3'b000;
            r_funct3E    <= 3'b000;
            r_rd1E       <= '0;
            r_rd2E       <= '0;
            r_immExtE    <= '0;
            r_pcE        <= !reset ? RESET_VECTOR : '0;
            r_pcPlus4E   <= '0;
            r_rs1E       <= 5'd0;
            r_rs2E       <= 5'd0;
            r_rdE        <= 5'd0;
            r_illegalE   <= 1'b0;
        end else begin
            r_regWriteE  <= w_regWrite;
            r_memWriteE  <= w_memWrite;
            r_branchE    <= w_branch;
            r_jumpE      <= w_jump;
            r_jalrE      <= w_jalr;
            r_aluSrcE    <= w_aluSrc;
            r_resultSrcE <= w_resultSrc;
            r_aluCtlE    <= w_aluCtl;
            r_funct3E    <= w_funct3;
            r_rd1E       <= w_rd1;
            r_rd2E       <= w_rd2;
            r_immExtE    <= w_immExt;
            r_pcE        <= bus.PCD;
            r_pcPlus4E   <= bus.PCPlus4D;
            r_rs1E       <= w_rs1;
            r_rs2E       <= w_rs2;
            r_rdE        <= w_rd;
            r_illegalE   <= w_illegal;
        end
    end

    assign bus.RegWriteE   = r_regWriteE;
    assign bus.MemWriteE   = r_memWriteE;
    assign bus.BranchE     = r_branchE;
    assign bus.JumpE       = r_jumpE;
    assign bus.JalrE       = r_jalrE;
    assign bus.ALUSrcE     = r_aluSrcE;
    assign bus.ResultSrcE  = r_resultSrcE;
    assign bus.ALUControlE = r_aluCtlE;
    assign bus.funct3E     = r_funct3E;
    assign bus.RD1E        = r_rd1E;
    assign bus.RD2E        = r_rd2E;
    assign bus.ImmExtE     = r_immExtE;
    assign bus.PCE         = r_pcE;
    assign bus.PCPlus4E    = r_pcPlus4E;
    assign bus.Rs1E        = r_rs1E;
    assign bus.Rs2E        = r_rs2E;
    assign bus.RdE         = r_rdE;
    assign bus.IllegalE    = r_illegalE;

endmodule
